mem_access_ctrl: RTL and testbench

//  Multicycle sequencer for the CPU's data-memory port. Accepts one load/store request at a time (word/half/byte).

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/mem_access_ctrl_byte_lane_merge.sv | 29 ++
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared size encodings and FSM state encoding for the data-memory sequencer.
// The ERR state only exists when MEM_ALIGN_CHECK_EN is defined.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10,
        LS_RSVD = 2'b11
    } ls_size_e;

`ifdef MEM_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, RD, WAIT, CAPT, WR, DONE, ERR} mem_state_e;
`else
    typedef enum logic [2:0] {IDLE, RD, WAIT, CAPT, WR, DONE} mem_state_e;
`endif

    // Byte offset of the accessed lane; word ignores addr[1:0], half ignores addr[0].
    function automatic logic [1:0] lane_of(input ls_size_e size, input logic [1:0] addr_lo);
        case (size)
            LS_BYTE: return addr_lo;
            LS_HALF: return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_merge.sv
// Combinational lane logic: read-modify-write merge for stores and the
// right-justifying lane shift for loads.
module byte_lane_merge
    import mips_mem_pkg::*;
(
    input  ls_size_e    size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rbuf_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_word_o
);

    logic [1:0] lane;

    assign lane = lane_of(size_i, addr_lo_i);

    always_comb begin
        store_word_o = rbuf_i;
        case (size_i)
            LS_HALF: store_word_o[{lane[1], 4'b0000} +: 16] = wdata_i[15:0];
            LS_BYTE: store_word_o[{lane, 3'b000} +: 8]      = wdata_i[7:0];
            default: store_word_o = wdata_i;
        endcase
    end

    assign load_word_o = rbuf_i >> {lane, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer for the single-port data memory.
// Optional alignment/reserved-size checking is enabled by MEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for req; the only state with busy low
// RD    | mem_rd strobe for the read of a load or sub-word store
// WAIT  | counting out the remaining read latency
// CAPT  | mem_rdata captured into rbuf
// WR    | store word prepared; mem_wr is strobed on the following cycle
// DONE  | ack is raised on the following cycle
// ERR   | rejected request; ack+err on the following cycle (check builds only)
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [31:0]       mdr_o,
    output logic [1:0]        ls_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    ls_size_e          size_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic              ack_q, busy_q, mem_rd_q, mem_wr_q;
    logic [31:0]       mdr_q, mem_wdata_q;
    logic [1:0]        ls_sel_q;
    logic [ADDR_W-1:0] mem_addr_q;

    ls_size_e          size_acc;
    logic              accept;
    logic              bad_req;
    logic [31:0]       store_word, load_word;

    assign accept = (state_q == IDLE) && req_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign size_acc = ls_size_e'(size_i);
    assign bad_req  = (size_i == LS_RSVD)
                   || ((size_i == LS_HALF) && addr_i[0])
                   || ((size_i == LS_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign size_acc = (size_i == LS_RSVD) ? LS_WORD : ls_size_e'(size_i);
    assign bad_req  = 1'b0;
`endif

    byte_lane_merge u_merge (
        .size_i       (size_q),
        .addr_lo_i    (addr_lo_q),
        .rbuf_i       (rbuf_q),
        .wdata_i      (wdata_q),
        .store_word_o (store_word),
        .load_word_o  (load_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (bad_req)
                        state_d = ERR;
                    else
`endif
                    if (we_i && (size_acc == LS_WORD))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = (RD_LAT == 1) ? CAPT : WAIT;
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1))
                    state_d = CAPT;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            CAPT:    state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_rd tracks the RD state itself; mem_wr and ack trail their states by
    // one cycle so a reset taken in WR cancels the write before it is issued.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= LS_WORD;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mdr_q       <= '0;
            mem_wdata_q <= '0;
            ls_sel_q    <= LS_WORD;
            mem_addr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != IDLE);
            mem_rd_q <= (state_d == RD);
            mem_wr_q <= (state_q == WR);
`ifdef MEM_ALIGN_CHECK_EN
            ack_q    <= (state_q == DONE) || (state_q == ERR);
`else
            ack_q    <= (state_q == DONE);
`endif
            if (accept) begin
                we_q       <= we_i;
                size_q     <= size_acc;
                addr_lo_q  <= addr_i[1:0];
                wdata_q    <= wdata_i;
                ls_sel_q   <= size_acc;
                mem_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
            end
            if (state_q == CAPT)
                rbuf_q <= mem_rdata_i;
            if (state_q == WR)
                mem_wdata_q <= store_word;
            if ((state_q == DONE) && !we_q)
                mdr_q <= load_word;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_q <= 1'b0;
        else
            err_q <= (state_q == ERR);
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o       = ack_q;
    assign busy_o      = busy_q;
    assign mdr_o       = mdr_q;
    assign ls_sel_o    = ls_sel_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with RD_LAT=1 and one with
// RD_LAT=3, each backed by a small behavioural memory.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RD_LAT = 1 instance
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, err, busy, mem_rd, mem_wr;
    logic [31:0] mdr, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  ls_sel;

    mem_access_ctrl #(.RD_LAT(1), .ADDR_W(32)) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .addr_i(addr), .wdata_i(wdata), .ack_o(ack), .err_o(err), .busy_o(busy),
        .mdr_o(mdr), .ls_sel_o(ls_sel), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // RD_LAT = 3 instance
    logic        req3 = 1'b0, we3 = 1'b0;
    logic [1:0]  size3 = 2'b00;
    logic [31:0] addr3 = '0, wdata3 = '0;
    logic        ack3, err3, busy3, mem_rd3, mem_wr3;
    logic [31:0] mdr3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [1:0]  ls_sel3;

    mem_access_ctrl #(.RD_LAT(3), .ADDR_W(32)) dut3 (
        .clk_i(clk), .reset_i(rst), .req_i(req3), .we_i(we3), .size_i(size3),
        .addr_i(addr3), .wdata_i(wdata3), .ack_o(ack3), .err_o(err3), .busy_o(busy3),
        .mdr_o(mdr3), .ls_sel_o(ls_sel3), .mem_addr_o(mem_addr3), .mem_rd_o(mem_rd3),
        .mem_wr_o(mem_wr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
    );

    // Memories: data is only valid in the cycle RD_LAT after the strobe.
    logic [31:0] mem  [0:255];
    logic [31:0] mem3 [0:255];
    logic        poke = 1'b0, poke3 = 1'b0;
    logic [7:0]  poke_a = '0;
    logic [31:0] poke_d = '0;
    logic        p1v = 1'b0, p2v = 1'b0;
    logic [31:0] p1 = '0, p2 = '0;

    always @(posedge clk) begin
        if (poke)        mem[poke_a] <= poke_d;
        else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_rd ? mem[mem_addr[9:2]] : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (poke3)        mem3[poke_a] <= poke_d;
        else if (mem_wr3) mem3[mem_addr3[9:2]] <= mem_wdata3;
        p1v <= mem_rd3;
        p1  <= mem3[mem_addr3[9:2]];
        p2v <= p1v;
        p2  <= p1;
        mem_rdata3 <= p2v ? p2 : 32'hDEADBEEF;
    end

    int both_strobes = 0;
    always @(negedge clk) if (mem_rd && mem_wr) both_strobes++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic sel3, input logic [7:0] a, input logic [31:0] d);
        poke_a = a; poke_d = d;
        if (sel3) poke3 = 1'b1; else poke = 1'b1;
        tick();
        poke = 1'b0; poke3 = 1'b0;
    endtask

    // Results of the last do_op, k = edges after the accept edge.
    int          ack_k, wr_k, nrd, nwr;
    logic        err_seen;
    logic [31:0] wd_seen;

    task automatic do_op(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        we = w; size = sz; addr = a; wdata = wd; req = 1'b1;
        tick();
        req = 1'b0;
        ack_k = -1; wr_k = -1; nrd = 0; nwr = 0; err_seen = 1'b0; wd_seen = '0;
        for (int k = 0; k < 16; k++) begin
            if (mem_rd) nrd++;
            if (mem_wr) begin nwr++; wr_k = k; wd_seen = mem_wdata; end
            if (ack) begin ack_k = k; err_seen = err; break; end
            tick();
        end
    endtask

    logic [15:0] rd_mask, ack_mask, idle_mask;
    logic [31:0] mdr3_first;
    int          late_acks;

    initial begin
        load_word(1'b0, 8'h40, 32'hAABBCCDD);
        load_word(1'b0, 8'h80, 32'h11223344);
        load_word(1'b0, 8'hC0, 32'h00000000);
        load_word(1'b1, 8'h40, 32'h44332211);
        load_word(1'b1, 8'h41, 32'h88776655);
        tick();

        check("rst_ack",       {31'd0, ack},    32'd0);
        check("rst_busy",      {31'd0, busy},   32'd0);
        check("rst_mem_rd",    {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("rst_err",       {31'd0, err},    32'd0);
        check("rst_mdr",       mdr,             32'd0);
        check("rst_mem_addr",  mem_addr,        32'd0);
        check("rst_mem_wdata", mem_wdata,       32'd0);
        check("rst_ls_sel",    {30'd0, ls_sel}, 32'd0);
        rst = 1'b0;
        tick();

        // load byte from lane 3
        do_op(1'b0, 2'b10, 32'h00000103, 32'h0);
        check("lb_ack_k",    32'(ack_k),      32'd3);
        check("lb_mdr",      mdr,             32'h000000AA);
        check("lb_mem_addr", mem_addr,        32'h00000100);
        check("lb_ls_sel",   {30'd0, ls_sel}, 32'd2);
        check("lb_nwr",      32'(nwr),        32'd0);
        check("lb_nrd",      32'(nrd),        32'd1);

        // store word: no read phase
        do_op(1'b1, 2'b00, 32'h00000300, 32'hCAFEF00D);
        check("sw_nrd",   32'(nrd),  32'd0);
        check("sw_wr_k",  32'(wr_k), 32'd1);
        check("sw_wdata", wd_seen,   32'hCAFEF00D);
        check("sw_ack_k", 32'(ack_k), 32'd2);
        check("sw_mem",   mem[8'hC0], 32'hCAFEF00D);

        // store half into upper lane
        do_op(1'b1, 2'b01, 32'h00000202, 32'h0000BEEF);
        check("sh_wdata", wd_seen,    32'hBEEF3344);
        check("sh_nwr",   32'(nwr),   32'd1);
        check("sh_wr_k",  32'(wr_k),  32'd3);
        check("sh_ack_k", 32'(ack_k), 32'd4);
        check("sh_mem",   mem[8'h80], 32'hBEEF3344);

        // load half back from upper lane
        do_op(1'b0, 2'b01, 32'h00000202, 32'h0);
        check("lh_mdr",   mdr,        32'h0000BEEF);
        check("lh_ack_k", 32'(ack_k), 32'd3);

        // misaligned word load
        do_op(1'b0, 2'b00, 32'h00000102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_ack_k", 32'(ack_k),       32'd1);
        check("mis_err",   {31'd0, err_seen}, 32'd1);
        check("mis_nrd",   32'(nrd),          32'd0);
        check("mis_mdr",   mdr,               32'h0000BEEF);
`else
        check("mis_ack_k", 32'(ack_k),       32'd3);
        check("mis_err",   {31'd0, err_seen}, 32'd0);
        check("mis_nrd",   32'(nrd),          32'd1);
        check("mis_mdr",   mdr,               32'hAABBCCDD);
        check("mis_addr",  mem_addr,          32'h00000100);
`endif
        check("one_strobe", 32'(both_strobes), 32'd0);

        // reset while a byte store sits in WR
        we = 1'b1; size = 2'b10; addr = 32'h00000201; wdata = 32'h0000005A; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        check("rw_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("rw_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("rw_ack",       {31'd0, ack},    32'd0);
        check("rw_busy",      {31'd0, busy},   32'd0);
        check("rw_mdr",       mdr,             32'd0);
        check("rw_mem_addr",  mem_addr,        32'd0);
        check("rw_mem_wdata", mem_wdata,       32'd0);
        check("rw_ls_sel",    {30'd0, ls_sel}, 32'd0);
        rst = 1'b0;
        late_acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack || mem_wr) late_acks++;
        end
        check("rw_no_ack", 32'(late_acks), 32'd0);
        check("rw_mem",    mem[8'h80],     32'hBEEF3344);

        // back-to-back loads with RD_LAT=3, req held high
        we3 = 1'b0; size3 = 2'b10; addr3 = 32'h00000101; req3 = 1'b1;
        tick();
        rd_mask = '0; ack_mask = '0; idle_mask = '0; mdr3_first = '0;
        for (int k = 0; k < 16; k++) begin
            if (mem_rd3) rd_mask[k]   = 1'b1;
            if (ack3)    ack_mask[k]  = 1'b1;
            if (!busy3)  idle_mask[k] = 1'b1;
            if (k == 5) begin
                mdr3_first = mdr3;
                size3 = 2'b01;
                addr3 = 32'h00000106;
            end
            if (k == 6) req3 = 1'b0;
            tick();
        end
        check("b2b_rd_mask",   {16'd0, rd_mask},   32'h00000041);
        check("b2b_ack_mask",  {16'd0, ack_mask},  32'h00000820);
        check("b2b_idle_mask", {16'd0, idle_mask}, 32'h0000F820);
        check("b2b_mdr_first", mdr3_first,         32'h00443322);
        check("b2b_mdr_second", mdr3,              32'h00008877);
        check("b2b_ls_sel",    {30'd0, ls_sel3},   32'd1);
        check("b2b_err",       {31'd0, err3},      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
